// File: rtl/cafe_pkg.sv
// Shared command codes and sequencer state encodings for the coffee dispenser.
package cafe_pkg;

  localparam logic [2:0] CMD_NONE     = 3'b000;
  localparam logic [2:0] CMD_DEVOLVER = 3'b001;
  localparam logic [2:0] CMD_CAFE     = 3'b010;
  localparam logic [2:0] CMD_DOBLE    = 3'b011;

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    IDLE     = 3'd1,
    MOLER    = 3'd2,
    CALENTAR = 3'd3,
    SERVIR   = 3'd4,
    DEVOLVER = 3'd5,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } estado_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cafe_temporizador.sv
// Loadable phase down-counter; holds at zero and flags it.
module cafe_temporizador #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = val_i;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cafe_dispensador.sv
// Coffee actuator sequencer: grind/heat/pour or coin return, with sensor aborts.
// Optional CAFE_DOBLE_EN: command 011 pours for twice the normal time.
module cafe_dispensador
  import cafe_pkg::*;
#(
  parameter int T_MOLER    = 4,
  parameter int T_CALENTAR = 6,
  parameter int T_SERVIR   = 8,
  parameter int T_DEVOLVER = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic       ha,
  input  logic       hc,
  output logic       molino,
  output logic       calentador,
  output logic       valvula_agua,
  output logic       devolver_moneda,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CW = $clog2(max4(T_MOLER, T_CALENTAR, T_SERVIR, T_DEVOLVER) * 2 + 1);

  estado_t        state_q, state_d;
  logic           load;
  logic [CW-1:0]  load_val;
  logic           zero;
  logic           es_cafe;
  logic [CW-1:0]  ld_servir;
  logic [6:0]     out_q, out_d;

`ifdef CAFE_DOBLE_EN
  logic doble_q, doble_d;
  assign es_cafe   = (cmd == CMD_CAFE) || (cmd == CMD_DOBLE);
  assign ld_servir = doble_q ? CW'(2 * T_SERVIR - 1) : CW'(T_SERVIR - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) doble_q <= 1'b0;
    else     doble_q <= doble_d;
  end
`else
  assign es_cafe   = (cmd == CMD_CAFE);
  assign ld_servir = CW'(T_SERVIR - 1);
`endif

  cafe_temporizador #(.W(CW)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .val_i  (load_val),
    .zero_o (zero)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
`ifdef CAFE_DOBLE_EN
    doble_d  = doble_q;
`endif
    case (state_q)
      ESPERA: if (cmd == CMD_NONE) state_d = IDLE;
      IDLE: begin
        if (es_cafe) begin
          if (ha && hc) begin
            state_d  = MOLER;
            load     = 1'b1;
            load_val = CW'(T_MOLER - 1);
`ifdef CAFE_DOBLE_EN
            doble_d  = (cmd == CMD_DOBLE);
`endif
          end else begin
            state_d = ERROR;
          end
        end else if (cmd == CMD_DEVOLVER) begin
          state_d  = DEVOLVER;
          load     = 1'b1;
          load_val = CW'(T_DEVOLVER - 1);
        end
      end
      // Sensor loss takes priority over a phase advance on the same edge.
      MOLER: begin
        if (!hc) state_d = ERROR;
        else if (zero) begin
          state_d  = CALENTAR;
          load     = 1'b1;
          load_val = CW'(T_CALENTAR - 1);
        end
      end
      CALENTAR: begin
        if (!ha) state_d = ERROR;
        else if (zero) begin
          state_d  = SERVIR;
          load     = 1'b1;
          load_val = ld_servir;
        end
      end
      SERVIR: begin
        if (!ha)       state_d = ERROR;
        else if (zero) state_d = DONE;
      end
      DONE:     state_d = ESPERA;
      DEVOLVER: if (zero) state_d = ESPERA;
      ERROR:    if (cmd == CMD_NONE) state_d = IDLE;
      default:  state_d = ESPERA;
    endcase
  end

  // Outputs decoded from the next state so they are registered yet change on the state edge.
  always_comb begin
    out_d    = '0;
    out_d[6] = (state_d == MOLER);
    out_d[5] = (state_d == CALENTAR);
    out_d[4] = (state_d == SERVIR);
    out_d[3] = (state_d == DEVOLVER);
    out_d[2] = (state_d == MOLER) || (state_d == CALENTAR) || (state_d == SERVIR) ||
               (state_d == DEVOLVER) || (state_d == DONE);
    out_d[1] = (state_d == DONE);
    out_d[0] = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ESPERA;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign {molino, calentador, valvula_agua, devolver_moneda, busy, done, error} = out_q;

endmodule

// File: tb/tb_cafe_dispensador.sv
// Directed table-driven bench for cafe_dispensador plus a hand-written mid-job reset sequence.
module tb_cafe_dispensador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd = 3'b000;
  logic       ha  = 1'b1;
  logic       hc  = 1'b1;
  logic       molino, calentador, valvula_agua, devolver_moneda, busy, done, error;

  int total = 0;
  int bad   = 0;

  cafe_dispensador dut (
    .clk             (clk),
    .rst             (rst),
    .cmd             (cmd),
    .ha              (ha),
    .hc              (hc),
    .molino          (molino),
    .calentador      (calentador),
    .valvula_agua    (valvula_agua),
    .devolver_moneda (devolver_moneda),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  // Expected output order: molino calentador valvula devolver busy done error
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_MOL  = 7'b1000100;
  localparam logic [6:0] O_CAL  = 7'b0100100;
  localparam logic [6:0] O_SRV  = 7'b0010100;
  localparam logic [6:0] O_DEV  = 7'b0001100;
  localparam logic [6:0] O_DONE = 7'b0000110;
  localparam logic [6:0] O_ERR  = 7'b0000001;

  typedef struct {
    logic       rst;
    logic [2:0] cmd;
    logic       ha;
    logic       hc;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] outs();
    return {molino, calentador, valvula_agua, devolver_moneda, busy, done, error};
  endfunction

  task automatic add(input logic r, input logic [2:0] c, input logic a, input logic h,
                     input int n, input logic [6:0] e);
    vec_t v;
    v.rst = r; v.cmd = c; v.ha = a; v.hc = h; v.n = n; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [6:0] want);
    total++;
    if (outs() !== want) begin
      bad++;
      $display("FAIL %s idx=%0d got=%b want=%b (mol cal val dev busy done err)",
               name, idx, outs(), want);
    end
  endtask

  task automatic cyc(input string name, input int idx, input logic [6:0] want);
    @(posedge clk);
    #1;
    check(name, idx, want);
  endtask

  initial begin
    // reset, then a full cafe job with cmd held (no re-trigger)
    add(1, 3'b000, 1, 1, 2, O_NONE);
    add(0, 3'b000, 1, 1, 1, O_NONE);
    add(0, 3'b010, 1, 1, 4, O_MOL);
    add(0, 3'b010, 1, 1, 6, O_CAL);
    add(0, 3'b010, 1, 1, 8, O_SRV);
    add(0, 3'b010, 1, 1, 1, O_DONE);
    add(0, 3'b010, 1, 1, 4, O_NONE);
    add(0, 3'b000, 1, 1, 1, O_NONE);
    // coin return, sensors ignored, no done pulse
    add(0, 3'b001, 0, 0, 2, O_DEV);
    add(0, 3'b001, 1, 1, 3, O_NONE);
    add(0, 3'b000, 1, 1, 1, O_NONE);
    // water lost on 3rd pour cycle
    add(0, 3'b010, 1, 1, 4, O_MOL);
    add(0, 3'b010, 1, 1, 6, O_CAL);
    add(0, 3'b010, 1, 1, 2, O_SRV);
    add(0, 3'b010, 0, 1, 3, O_ERR);
    add(0, 3'b000, 0, 1, 1, O_NONE);
    // coffee lost mid-grind
    add(0, 3'b010, 1, 1, 2, O_MOL);
    add(0, 3'b010, 1, 0, 2, O_ERR);
    add(0, 3'b000, 1, 1, 1, O_NONE);
    // hc missing at start: straight to ERROR, back to IDLE (not ESPERA)
    add(0, 3'b010, 1, 0, 3, O_ERR);
    add(0, 3'b000, 1, 1, 1, O_NONE);
    add(0, 3'b001, 1, 1, 1, O_DEV);
    add(0, 3'b000, 1, 1, 1, O_DEV);
    add(0, 3'b000, 1, 1, 2, O_NONE);
    // unknown codes ignored in IDLE
    add(0, 3'b100, 1, 1, 2, O_NONE);
    add(0, 3'b101, 1, 1, 1, O_NONE);
    add(0, 3'b110, 1, 1, 1, O_NONE);
    add(0, 3'b111, 1, 1, 1, O_NONE);
`ifdef CAFE_DOBLE_EN
    add(0, 3'b011, 1, 1, 4, O_MOL);
    add(0, 3'b011, 1, 1, 6, O_CAL);
    add(0, 3'b011, 1, 1, 16, O_SRV);
    add(0, 3'b011, 1, 1, 1, O_DONE);
    add(0, 3'b011, 1, 1, 2, O_NONE);
    add(0, 3'b000, 1, 1, 1, O_NONE);
`else
    add(0, 3'b011, 1, 1, 4, O_NONE);
    add(0, 3'b000, 1, 1, 1, O_NONE);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; cmd = vecs[i].cmd; ha = vecs[i].ha; hc = vecs[i].hc;
      for (int k = 0; k < vecs[i].n; k++) cyc("vec", i, vecs[i].exp);
    end

    // async reset mid-heat with cmd still 010
    cmd = 3'b010; ha = 1'b1; hc = 1'b1;
    for (int k = 0; k < 4; k++) cyc("rst_mol", k, O_MOL);
    for (int k = 0; k < 2; k++) cyc("rst_cal", k, O_CAL);
    #3 rst = 1'b1;
    #1 check("rst_async", 0, O_NONE);
    cyc("rst_hold", 0, O_NONE);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc("rst_espera", k, O_NONE);
    cmd = 3'b000;
    cyc("rst_idle", 0, O_NONE);
    cmd = 3'b010;
    cyc("rst_restart", 0, O_MOL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
